// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle of the multicycle CPU: instruction/status in, enables and selects out.
// Master is the controller, slave is the datapath.
interface multicycle_control_if #(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 32
);
  logic [5:0]          opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_en;
  logic [1:0]          pc_source;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                halted;
  logic                illegal;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, illegal, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM of the multicycle CPU; outputs are registered per state, 2-5 cycles per instruction.
// mem_ready low holds FETCH/MEM_RD/MEM_WR with frozen outputs; only ir_write/pc_en see mem_ready/zero live.
module multicycle_control #(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [ALU_OP_W-1:0] OP_ADD = ALU_OP_W'(4'b0010);
  localparam logic [ALU_OP_W-1:0] OP_SUB = ALU_OP_W'(4'b0011);

  state_t              state_q, state_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                fetch_q, fetch_d;
  logic                jump_q, jump_d;
  logic                branch_q, branch_d;
  logic                branch_ne_q, branch_ne_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                i_or_d_q, i_or_d_d;
  logic                reg_write_q, reg_write_d;
  logic                reg_dst_q, reg_dst_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic                alu_src_a_q, alu_src_a_d;
  logic [1:0]          alu_src_b_q, alu_src_b_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [1:0]          pc_source_q, pc_source_d;
  logic                halted_q, halted_d;

  logic [1:0] op_cls;
  logic [3:0] op_fn;
  logic       op_legal;

  assign op_cls = bus.opcode[5:4];
  assign op_fn  = bus.opcode[3:0];

  always_comb begin
    op_legal = 1'b0;
    unique case (op_cls)
      2'b00:   op_legal = (op_fn inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd15});
      2'b01:   op_legal = !op_fn[3];
      2'b11:   op_legal = (op_fn inside {[4'd2:4'd7], 4'd9, 4'd10});
      default: op_legal = (op_fn[3:1] == 3'b000);
    endcase
  end

  // Next state, sticky illegal flag and retired-instruction counter.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!op_legal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          unique case (op_cls)
            2'b00: begin
              if (op_fn == 4'd15)           state_d = S_HALT;
              else if (op_fn == 4'd0)       state_d = S_FETCH;
              else if (op_fn == 4'd1)       state_d = S_JUMP;
              else                          state_d = S_BRANCH;
            end
            2'b01:   state_d = S_EXEC_R;
            2'b11:   state_d = S_EXEC_I;
            default: state_d = S_MEM_ADDR;
          endcase
        end
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = bus.opcode[0] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
      retired_d = retired_q + CNT_W'(1);
  end

  // Outputs are computed for the state being entered so they come straight from flops.
  always_comb begin
    fetch_d      = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    branch_ne_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    i_or_d_d     = 1'b0;
    reg_write_d  = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    alu_op_d     = '0;
    pc_source_d  = 2'b00;
    halted_d     = 1'b0;
    unique case (state_d)
      S_FETCH: begin
        fetch_d     = 1'b1;
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
        alu_op_d    = OP_ADD;
      end
      S_DECODE: begin
        alu_src_b_d = 2'b10;
        alu_op_d    = OP_ADD;
      end
      S_EXEC_R: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = ALU_OP_W'(op_fn);
      end
      S_EXEC_I: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = (op_fn == 4'b1010) ? 2'b11 : 2'b10;
        alu_op_d    = ALU_OP_W'(op_fn);
      end
      S_WB_R: reg_write_d = 1'b1;
      S_WB_I: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        alu_op_d    = OP_ADD;
      end
      S_MEM_RD: begin
        mem_read_d = 1'b1;
        i_or_d_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_d  = 1'b1;
        reg_dst_d    = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_d = 1'b1;
        i_or_d_d    = 1'b1;
      end
      S_BRANCH: begin
        branch_d    = 1'b1;
        branch_ne_d = bus.opcode[0];
        alu_src_a_d = 1'b1;
        alu_op_d    = OP_SUB;
        pc_source_d = 2'b01;
      end
      S_JUMP: begin
        jump_d      = 1'b1;
        pc_source_d = 2'b10;
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      illegal_q    <= 1'b0;
      retired_q    <= '0;
      fetch_q      <= 1'b0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      branch_ne_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      i_or_d_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= '0;
      pc_source_q  <= 2'b00;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_q    <= illegal_d;
      retired_q    <= retired_d;
      fetch_q      <= fetch_d;
      jump_q       <= jump_d;
      branch_q     <= branch_d;
      branch_ne_q  <= branch_ne_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      i_or_d_q     <= i_or_d_d;
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
      pc_source_q  <= pc_source_d;
      halted_q     <= halted_d;
    end
  end

  // Branch condition: BEQ takes on zero, BNE on not-zero.
  assign bus.pc_en      = (fetch_q & bus.mem_ready) | jump_q | (branch_q & (bus.zero ^ branch_ne_q));
  assign bus.ir_write   = fetch_q & bus.mem_ready;
  assign bus.pc_source  = pc_source_q;
  assign bus.i_or_d     = i_or_d_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.reg_dst    = reg_dst_q;
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.alu_src_a  = alu_src_a_q;
  assign bus.alu_src_b  = alu_src_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.halted     = halted_q;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each instruction is expanded into its expected
// per-cycle output list, and one negedge process compares the DUT against that list.
module tb_multicycle_control;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;

  multicycle_control_if #(.ALU_OP_W(4), .CNT_W(CNT_W)) bus ();
  multicycle_control #(.ALU_OP_W(4), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pc_en;
    logic [1:0]       pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [5:0] opc;
    logic       zero;
    logic       mr;
    int         tag;
    exp_t       e;
  } cyc_t;

  cyc_t             sched[$];
  logic [CNT_W-1:0] m_retired;
  logic             m_illegal;
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cur      = 0;
  bit               active   = 1'b0;
  int cyc_cnt[8]  = '{default: 0};
  int rw_cnt[8]   = '{default: 0};
  int rwm_cnt[8]  = '{default: 0};
  int pc01_cnt[8] = '{default: 0};
  int lui_cnt[8]  = '{default: 0};
  int halt_cnt[8] = '{default: 0};

  exp_t act;
  cyc_t cmp_rec;
  assign act = {bus.pc_en, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.halted, bus.illegal, bus.retired};

  function automatic exp_t blank();
    exp_t e;
    e         = '0;
    e.illegal = m_illegal;
    e.retired = m_retired;
    return e;
  endfunction

  task automatic push(input exp_t e, input logic r, input logic [5:0] opc, input logic z,
                      input logic mr, input int tag);
    cyc_t c;
    c.rst = r; c.opc = opc; c.zero = z; c.mr = mr; c.tag = tag; c.e = e;
    sched.push_back(c);
  endtask

  task automatic add_reset(input int n);
    m_retired = '0;
    m_illegal = 1'b0;
    for (int i = 0; i < n; i++) push(blank(), 1'b1, 6'd0, 1'b0, 1'b1, 0);
    push(blank(), 1'b0, 6'd0, 1'b0, 1'b1, 0);
  endtask

  // Expected cycle list for one instruction: fst fetch stalls, mst memory stalls.
  task automatic add_instr(input logic [5:0] opc, input logic z, input int fst, input int mst,
                           input int tag, input int nhalt);
    exp_t       e;
    logic [1:0] cls;
    logic [3:0] fn;
    bit         legal;
    cls = opc[5:4];
    fn  = opc[3:0];
    case (cls)
      2'b00:   legal = (fn <= 4'd3) || (fn == 4'd15);
      2'b01:   legal = (fn <= 4'd7);
      2'b11:   legal = ((fn >= 4'd2) && (fn <= 4'd7)) || (fn == 4'd9) || (fn == 4'd10);
      default: legal = (fn <= 4'd1);
    endcase
    for (int i = 0; i < fst; i++) begin
      e = blank(); e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 4'b0010;
      push(e, 1'b0, opc, z, 1'b0, tag);
    end
    e = blank(); e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 4'b0010;
    e.ir_write = 1'b1; e.pc_en = 1'b1;
    push(e, 1'b0, opc, z, 1'b1, tag);
    e = blank(); e.alu_src_b = 2'b10; e.alu_op = 4'b0010;
    push(e, 1'b0, opc, z, 1'b1, tag);
    if (!legal || opc == 6'b001111) begin
      if (!legal) m_illegal = 1'b1;
      for (int i = 0; i < nhalt; i++) begin
        e = blank(); e.halted = 1'b1;
        push(e, 1'b0, opc, z, ((i % 2) == 1), tag);
      end
      return;
    end
    case (cls)
      2'b00: begin
        if (fn == 4'd1) begin
          e = blank(); e.pc_en = 1'b1; e.pc_source = 2'b10;
          push(e, 1'b0, opc, z, 1'b1, tag);
        end else if (fn != 4'd0) begin
          e = blank(); e.alu_src_a = 1'b1; e.alu_op = 4'b0011; e.pc_source = 2'b01;
          e.pc_en = (fn == 4'd2) ? z : !z;
          push(e, 1'b0, opc, z, 1'b1, tag);
        end
      end
      2'b01, 2'b11: begin
        e = blank(); e.alu_src_a = 1'b1; e.alu_op = fn;
        if (cls == 2'b11) e.alu_src_b = (fn == 4'd10) ? 2'b11 : 2'b10;
        push(e, 1'b0, opc, z, 1'b1, tag);
        e = blank(); e.reg_write = 1'b1; e.reg_dst = (cls == 2'b11);
        push(e, 1'b0, opc, z, 1'b1, tag);
      end
      default: begin
        e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 4'b0010;
        push(e, 1'b0, opc, z, 1'b1, tag);
        e = blank(); e.i_or_d = 1'b1;
        if (fn == 4'd0) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        for (int i = 0; i < mst; i++) push(e, 1'b0, opc, z, 1'b0, tag);
        push(e, 1'b0, opc, z, 1'b1, tag);
        if (fn == 4'd0) begin
          e = blank(); e.reg_write = 1'b1; e.reg_dst = 1'b1; e.mem_to_reg = 1'b1;
          push(e, 1'b0, opc, z, 1'b1, tag);
        end
      end
    endcase
    m_retired = m_retired + 1'b1;
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      cmp_rec = sched[cur];
      n_checks++;
      if (act !== cmp_rec.e) begin
        n_fail++;
        $display("FAIL cycle %0d tag %0d opcode %b rst %b: outputs got %h expected %h",
                 cur, cmp_rec.tag, cmp_rec.opc, cmp_rec.rst, act, cmp_rec.e);
      end
      cyc_cnt[cmp_rec.tag]++;
      if (bus.reg_write) rw_cnt[cmp_rec.tag]++;
      if (bus.reg_write && bus.mem_to_reg) rwm_cnt[cmp_rec.tag]++;
      if (bus.pc_en && bus.pc_source == 2'b01) pc01_cnt[cmp_rec.tag]++;
      if (bus.alu_op == 4'b1010 && bus.alu_src_b == 2'b11) lui_cnt[cmp_rec.tag]++;
      if (bus.halted) halt_cnt[cmp_rec.tag]++;
    end
  end

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    m_retired     = '0;
    m_illegal     = 1'b0;

    add_reset(2);
    add_instr(6'b000000, 1'b0, 0, 0, 1, 0);  // NOP
    add_instr(6'b010010, 1'b0, 0, 0, 2, 0);  // ADD
    add_instr(6'b111010, 1'b0, 0, 0, 3, 0);  // LUI
    add_instr(6'b010011, 1'b1, 1, 0, 0, 0);  // SUB, fetch stall
    add_instr(6'b110110, 1'b0, 0, 0, 0, 0);  // XORI
    add_instr(6'b100000, 1'b0, 0, 3, 4, 0);  // LW, 3 read stalls
    add_instr(6'b100001, 1'b0, 2, 1, 0, 0);  // SW, fetch and write stalls
    add_instr(6'b000001, 1'b0, 0, 0, 0, 0);  // JMP
    add_instr(6'b000010, 1'b1, 0, 0, 5, 0);  // BEQ taken
    add_instr(6'b000011, 1'b1, 0, 0, 6, 0);  // BNE not taken
    add_instr(6'b000010, 1'b0, 0, 0, 0, 0);  // BEQ not taken
    add_instr(6'b000011, 1'b0, 0, 0, 0, 0);  // BNE taken
    add_instr(6'b111001, 1'b0, 0, 0, 0, 0);  // LI
    add_instr(6'b010111, 1'b0, 0, 0, 0, 0);  // SLT
    add_instr(6'b010000, 1'b0, 0, 0, 0, 0);  // MOV
    // LW cut short by reset while stalled in MEM_RD
    add_instr(6'b100000, 1'b0, 0, 3, 0, 0);
    repeat (3) void'(sched.pop_back());
    add_reset(1);
    repeat (18) add_instr(6'b000000, 1'b0, 0, 0, 0, 0);  // counter wrap
    add_instr(6'b001111, 1'b0, 0, 0, 0, 5);  // HALT
    add_reset(1);
    add_instr(6'b111000, 1'b0, 0, 0, 0, 3);  // illegal immediate
    add_reset(1);
    add_instr(6'b010010, 1'b0, 0, 0, 0, 0);
    add_instr(6'b100111, 1'b0, 0, 0, 7, 100);  // illegal memory op

    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clk);
      #1;
      rst           = sched[i].rst;
      bus.opcode    = sched[i].opc;
      bus.zero      = sched[i].zero;
      bus.mem_ready = sched[i].mr;
      cur           = i;
      active        = 1'b1;
    end
    @(negedge clk);
    #1;
    active = 1'b0;

    check_lit("nop_cycles", cyc_cnt[1], 2);
    check_lit("add_cycles", cyc_cnt[2], 4);
    check_lit("add_reg_write", rw_cnt[2], 1);
    check_lit("lui_exec", lui_cnt[3], 1);
    check_lit("lw_cycles", cyc_cnt[4], 8);
    check_lit("lw_mem_to_reg_writes", rwm_cnt[4], 1);
    check_lit("beq_cycles", cyc_cnt[5], 3);
    check_lit("beq_taken", pc01_cnt[5], 1);
    check_lit("bne_cycles", cyc_cnt[6], 3);
    check_lit("bne_not_taken", pc01_cnt[6], 0);
    check_lit("illegal_halt_cycles", halt_cnt[7], 100);
    check_lit("illegal_flag_end", int'(bus.illegal), 1);
    check_lit("retired_frozen_end", int'(bus.retired), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
